// File: rtl/abro_seq_detector.sv
// ABRO detector: raises O once both A and B have been seen, in either order or together.
// Optional synchronous restart input R is compiled in when ABRO_RESTART_EN is defined.
module abro_seq_detector #(
   parameter int unsigned O_PULSE     = 0,
   parameter int unsigned SYNC_STAGES = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       A,
   input  logic       B,
`ifdef ABRO_RESTART_EN
   input  logic       R,
`endif
   output logic       O,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBSeen = 2'b01,
      StASeen = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e state_q, state_d;
   logic   o_q;
   logic   a_s, b_s;

   // Optional input delay line; every stage is cleared by reset.
   if (SYNC_STAGES == 0) begin : g_nosync
      assign a_s = A;
      assign b_s = B;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
         end else begin
            a_q[0] <= A;
            b_q[0] <= B;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               a_q[i] <= a_q[i-1];
               b_q[i] <= b_q[i-1];
            end
         end
      end

      assign a_s = a_q[SYNC_STAGES-1];
      assign b_s = b_q[SYNC_STAGES-1];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (a_s && b_s)      state_d = StDone;
            else if (a_s)        state_d = StASeen;
            else if (b_s)        state_d = StBSeen;
         end
         StASeen: if (b_s)      state_d = StDone;
         StBSeen: if (a_s)      state_d = StDone;
         StDone:  if (O_PULSE != 0) state_d = StIdle;
         default:               state_d = StIdle;
      endcase
`ifdef ABRO_RESTART_EN
      // Restart discards any arrivals sampled at the same edge.
      if (R) state_d = StIdle;
`endif
   end

   // O is registered from the next state so it always equals (state_q == StDone).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         o_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         o_q     <= (state_d == StDone);
      end
   end

   assign state = state_q;
   assign O     = o_q;

endmodule

// File: tb/tb_abro_seq_detector.sv
// Scoreboard bench for abro_seq_detector: three instances cover the default build,
// pulse mode and two-stage input delay.
module tb_abro_seq_detector;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       a0 = 1'b1, b0 = 1'b1, a1 = 1'b1, b1 = 1'b1, a2 = 1'b1, b2 = 1'b1;
   logic       o0, o1, o2;
   logic [1:0] st0, st1, st2;
   logic       r_drv = 1'b0;
   logic       check_now = 1'b0;
`ifdef ABRO_RESTART_EN
   logic       R = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int         id;
      logic [1:0] st;
      logic       o;
      string      name;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   abro_seq_detector #(.O_PULSE(0), .SYNC_STAGES(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .A(a0), .B(b0),
`ifdef ABRO_RESTART_EN
      .R(R),
`endif
      .O(o0), .state(st0)
   );

   abro_seq_detector #(.O_PULSE(1), .SYNC_STAGES(0)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .A(a1), .B(b1),
`ifdef ABRO_RESTART_EN
      .R(R),
`endif
      .O(o1), .state(st1)
   );

   abro_seq_detector #(.O_PULSE(0), .SYNC_STAGES(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .A(a2), .B(b2),
`ifdef ABRO_RESTART_EN
      .R(R),
`endif
      .O(o2), .state(st2)
   );

   // Monitor: drains expectations just after each clock edge or an async check request.
   initial begin
      exp_t       e;
      logic [1:0] as;
      logic       ao;
      forever begin
         @(posedge clk or posedge check_now);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
               0:       begin as = st0; ao = o0; end
               1:       begin as = st1; ao = o1; end
               default: begin as = st2; ao = o2; end
            endcase
            n_checks++;
            if (as === e.st && ao === e.o) n_pass++;
            else $display("FAIL %s: dut%0d got state=%b O=%b, expected state=%b O=%b",
                          e.name, e.id, as, ao, e.st, e.o);
         end
      end
   end

   task automatic push(input int id, input logic [1:0] st, input logic o, input string name);
      exp_t e;
      e.id = id; e.st = st; e.o = o; e.name = name;
      q.push_back(e);
   endtask

   task automatic step(input int id, input logic a, input logic b,
                       input logic [1:0] st, input logic o, input string name);
      @(negedge clk);
`ifdef ABRO_RESTART_EN
      R = r_drv;
`endif
      case (id)
         0:       begin a0 = a; b0 = b; end
         1:       begin a1 = a; b1 = b; end
         default: begin a2 = a; b2 = b; end
      endcase
      push(id, st, o, name);
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset_n = 1'b0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with A=B=1 on every instance.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         push(0, 2'b00, 1'b0, "reset_hold");
         push(1, 2'b00, 1'b0, "reset_hold");
         push(2, 2'b00, 1'b0, "reset_hold");
         @(posedge clk);
         #2;
      end
      @(negedge clk);
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
      reset_n = 1'b1;

      // A then B.
      step(0, 1, 0, 2'b10, 0, "ab_a");
      step(0, 0, 1, 2'b11, 1, "ab_b");
      for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b11, 1, "ab_hold");

      // Async reset mid-cycle from DONE.
      reset_n = 1'b0;
      push(0, 2'b00, 1'b0, "async_reset");
      check_now = 1'b1;
      #2;
      check_now = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // B then A, with a long B-only wait and a held A afterwards.
      step(0, 0, 1, 2'b01, 0, "ba_b");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b01, 0, "ba_wait");
      step(0, 0, 1, 2'b01, 0, "ba_b_again");
      step(0, 1, 0, 2'b11, 1, "ba_a");
      step(0, 1, 1, 2'b11, 1, "done_ignores");
      reset_pulse();

      // Simultaneous arrival.
      step(0, 1, 1, 2'b11, 1, "simul");
      reset_pulse();

      // Pulse mode: one-cycle O, no banking while A=B stay high.
      step(1, 1, 1, 2'b11, 1, "pulse_done");
      step(1, 1, 1, 2'b00, 0, "pulse_idle");
      step(1, 1, 1, 2'b11, 1, "pulse_reenter");
      step(1, 0, 0, 2'b00, 0, "pulse_idle2");
      step(1, 1, 0, 2'b10, 0, "pulse_a");
      step(1, 1, 0, 2'b10, 0, "pulse_a_held");
      step(1, 0, 1, 2'b11, 1, "pulse_b");
      step(1, 0, 0, 2'b00, 0, "pulse_back");

      // Two-stage input delay.
      step(2, 1, 1, 2'b00, 0, "sync_e1");
      step(2, 1, 1, 2'b00, 0, "sync_e2");
      step(2, 1, 1, 2'b11, 1, "sync_e3");
      step(2, 0, 0, 2'b11, 1, "sync_hold");
      reset_pulse();
      step(2, 1, 0, 2'b00, 0, "sync_a_e1");
      step(2, 0, 0, 2'b00, 0, "sync_a_e2");
      step(2, 0, 0, 2'b10, 0, "sync_a_e3");
      reset_pulse();

`ifdef ABRO_RESTART_EN
      step(0, 1, 0, 2'b10, 0, "rst_a");
      r_drv = 1'b1;
      step(0, 0, 1, 2'b00, 0, "rst_wins");
      r_drv = 1'b0;
      step(0, 1, 1, 2'b11, 1, "rst_done");
      r_drv = 1'b1;
      step(0, 0, 0, 2'b00, 0, "rst_from_done");
      r_drv = 1'b0;
      step(0, 0, 0, 2'b00, 0, "rst_idle");
`endif

      @(posedge clk);
      #3;
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
